// File: rtl/code_stepper_if.sv
// code_stepper_if
//   Groups the control inputs and the code/strobe outputs of code_stepper.
//   master : the side that drives button/direction/auto/load and watches the code
//   slave  : code_stepper itself
//
//   step_btn   raw push-button, high = pressed (asynchronous, bouncing)
//   up_dn      step direction, 1 = +1, 0 = -1
//   auto_en    1 = timer-driven stepping, button ignored
//   load       synchronous load strobe, highest priority
//   load_val   value written to code on load
//   code       current 3-bit code, registered
//   code_valid one-cycle pulse in the first cycle a new code is visible
//   wrap       one-cycle pulse with code_valid on a 7->0 or 0->7 step
interface code_stepper_if;
    logic       step_btn;
    logic       up_dn;
    logic       auto_en;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] code;
    logic       code_valid;
    logic       wrap;

    modport master (
        output step_btn, up_dn, auto_en, load, load_val,
        input  code, code_valid, wrap
    );

    modport slave (
        input  step_btn, up_dn, auto_en, load, load_val,
        output code, code_valid, wrap
    );
endinterface

// File: rtl/code_stepper.sv
// code_stepper
//   Generates the 3-bit code feeding the 3-to-4 code converter. The code
//   advances on a debounced button press, on a free-running prescaler when
//   auto_en is high, or is written directly by a synchronous load.
//
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    code_stepper_if.slave (controls in, code/code_valid/wrap out)
//
//   DB_CYCLES   (>=1) consecutive stable cycles needed to accept a button level
//   AUTO_PERIOD (>=2) cycles between automatic steps
module code_stepper #(
    parameter int DB_CYCLES   = 16,
    parameter int AUTO_PERIOD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    code_stepper_if.slave bus
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int PSW = $clog2(AUTO_PERIOD);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [PSW-1:0] PS_LAST = PSW'(AUTO_PERIOD - 1);

    logic           s1_q, s2_q;
    logic           db_level_q, db_level_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           btn_step_q, btn_step_d;
    logic [PSW-1:0] presc_q, presc_d;
    logic [2:0]     code_q, code_d;
    logic           valid_q, valid_d;
    logic           wrap_q, wrap_d;

    logic           auto_step;
    logic           step;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt_q   <= '0;
            btn_step_q <= 1'b0;
            presc_q    <= '0;
            code_q     <= 3'd0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            s1_q       <= bus.step_btn;
            s2_q       <= s1_q;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            btn_step_q <= btn_step_d;
            presc_q    <= presc_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            wrap_q     <= wrap_d;
        end
    end

    // Debouncer: the level is accepted on the edge where the disagreement
    // count would reach DB_CYCLES, so the count never actually holds that value.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        btn_step_d = 1'b0;
        if (s2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = s2_q;
                btn_step_d = s2_q;   // press only; release is silent
            end else begin
                db_cnt_d = db_cnt_q + DBW'(1);
            end
        end
    end

    // Prescaler: the step fires on the same edge the count wraps.
    always_comb begin
        auto_step = bus.auto_en && (presc_q == PS_LAST);
        if (!bus.auto_en || bus.load || auto_step) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PSW'(1);
        end
    end

    // Code update: load beats any step; a button pulse in auto mode is lost.
    always_comb begin
        step    = bus.auto_en ? auto_step : btn_step_q;
        code_d  = code_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (bus.load) begin
            code_d  = bus.load_val;
            valid_d = 1'b1;
        end else if (step) begin
            valid_d = 1'b1;
            if (bus.up_dn) begin
                code_d = code_q + 3'd1;
                wrap_d = (code_q == 3'd7);
            end else begin
                code_d = code_q - 3'd1;
                wrap_d = (code_q == 3'd0);
            end
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = valid_q;
    assign bus.wrap       = wrap_q;

endmodule
